bird_motion_ctrl: RTL and testbench

BIRD_MOTION_CTRL -- requirements
Module: bird_motion_ctrl

---
 rtl/bird_motion_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion_ctrl.sv
// -----------------------------------------------------------------------------
// bird_motion_ctrl
//
// Vertical motion and game-state controller for the flappy-bird demo. The bird
// falls under a constant per-frame gravity and gets a fixed upward velocity
// each time the button is pressed. All motion is applied once per video frame,
// at the start of vertical blanking, so the rendered bird never tears.
//
// Parameters
//   Y_INIT      bird top row while waiting in READY (pixels)
//   Y_MAX       lowest legal top row; reaching it ends the run
//   GRAVITY     velocity increment per frame
//   FLAP_VEL    velocity loaded by a flap (signed, negative = upward)
//   VMAX        terminal (maximum downward) velocity
//   DEAD_FRAMES minimum frames spent in DEAD before a flap restarts the game
//
// Ports
//   dclk         in   25 MHz pixel clock, the only clock
//   clr          in   synchronous active-high reset
//   vsync        in   active-low vertical sync from the 640x480 timing gen
//   flap         in   debounced, asynchronous button level
//   bird_y       out  [9:0]  registered bird top row (renderer square_top)
//   state        out  [1:0]  0=READY, 1=PLAY, 2=DEAD
//   game_over    out  high exactly while state is DEAD
//   alive_frames out  [15:0] frames survived in the current run (saturating)
// -----------------------------------------------------------------------------
module bird_motion_ctrl #(
    parameter int Y_INIT      = 215,
    parameter int Y_MAX       = 430,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = -8,
    parameter int VMAX        = 10,
    parameter int DEAD_FRAMES = 60
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        vsync,
    input  logic        flap,
    output logic [9:0]  bird_y,
    output logic [1:0]  state,
    output logic        game_over,
    output logic [15:0] alive_frames
);

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_PLAY    = 2'd1,
        ST_DEAD    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam int DC_W = (DEAD_FRAMES < 1) ? 1 : $clog2(DEAD_FRAMES + 1);

    localparam logic signed [10:0] Y_INIT_V  = 11'(Y_INIT);
    localparam logic signed [10:0] Y_MAX_V   = 11'(Y_MAX);
    localparam logic signed [11:0] Y_MAX_S   = 12'(Y_MAX);
    localparam logic signed [4:0]  FLAP_V    = 5'(FLAP_VEL);
    localparam logic signed [4:0]  VMAX_V    = 5'(VMAX);
    localparam logic signed [6:0]  VMAX_S    = 7'(VMAX);
    localparam logic signed [6:0]  GRAVITY_S = 7'(GRAVITY);
    localparam logic [DC_W-1:0]    DEAD_MAX  = DC_W'(DEAD_FRAMES);

    // -------------------------------------------------------------------------
    // Button synchronizer and rising-edge detector.
    // r_flap_s1/s2 form the 2-flop synchronizer, r_flap_s3 is the previous
    // synchronized level, and r_flap_evt is the registered one-cycle pulse,
    // three dclk after the pin.
    //
    // The pipeline resets to 0, so a button held through reset would look
    // like a fresh rising edge once real samples arrive. r_settle waits until
    // r_flap_s2 carries a real pin sample, and r_flap_armed only rises once
    // that sample has been seen low; until then no event can be produced.
    // -------------------------------------------------------------------------
    logic       r_flap_s1;
    logic       r_flap_s2;
    logic       r_flap_s3;
    logic       r_flap_evt;
    logic       r_flap_armed;
    logic [1:0] r_settle;

    always_ff @(posedge dclk) begin
        if (clr) begin
            r_flap_s1    <= 1'b0;
            r_flap_s2    <= 1'b0;
            r_flap_s3    <= 1'b0;
            r_flap_evt   <= 1'b0;
            r_flap_armed <= 1'b0;
            r_settle     <= 2'd0;
        end else begin
            r_flap_s1    <= flap;
            r_flap_s2    <= r_flap_s1;
            r_flap_s3    <= r_flap_s2;
            r_flap_evt   <= r_flap_armed & r_flap_s2 & ~r_flap_s3;
            r_settle     <= (r_settle == 2'd2) ? 2'd2 : r_settle + 2'd1;
            r_flap_armed <= r_flap_armed | ((r_settle == 2'd2) & ~r_flap_s2);
        end
    end

    // -------------------------------------------------------------------------
    // Frame tick: one-cycle pulse on the cycle after vsync's falling edge has
    // been registered, i.e. once per frame at the start of vertical blanking.
    // The edge register resets high so reset itself never counts as an edge,
    // but a vsync that is already low when reset releases does produce a tick.
    // -------------------------------------------------------------------------
    logic r_vsync_q;
    logic r_frame_tick;

    always_ff @(posedge dclk) begin
        if (clr) begin
            r_vsync_q    <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_vsync_q    <= vsync;
            r_frame_tick <= r_vsync_q & ~vsync;
        end
    end

    // -------------------------------------------------------------------------
    // Game state and motion registers
    // -------------------------------------------------------------------------
    state_t                r_state;
    logic signed [10:0]    r_y;
    logic signed [4:0]     r_vel;
    logic                  r_pending;
    logic [DC_W-1:0]       r_dead_cnt;
    logic [15:0]           r_alive;

    state_t                w_state_nxt;
    logic signed [10:0]    w_y_nxt;
    logic signed [4:0]     w_vel_nxt;
    logic                  w_pending_nxt;
    logic [DC_W-1:0]       w_dead_nxt;
    logic [15:0]           w_alive_nxt;

    // Motion arithmetic, widened so that neither the position sum nor the
    // gravity step can wrap before it is range-checked.
    logic signed [11:0]    w_y_sum;
    logic signed [6:0]     w_vel_grav;
    logic signed [4:0]     w_vel_cap;
    logic                  w_flap_now;
    logic [15:0]           w_alive_inc;

    assign w_y_sum     = {r_y[10], r_y} + {{7{r_vel[4]}}, r_vel};
    assign w_vel_grav  = {{2{r_vel[4]}}, r_vel} + GRAVITY_S;
    assign w_alive_inc = (r_alive == 16'hFFFF) ? r_alive : r_alive + 16'd1;
    // A flap arriving on the tick cycle itself counts the same as a pending one.
    assign w_flap_now  = r_pending | r_flap_evt;

    always_comb begin
        w_vel_cap = w_vel_grav[4:0];
        if (w_vel_grav > VMAX_S) begin
            w_vel_cap = VMAX_V;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_y_nxt       = r_y;
        w_vel_nxt     = r_vel;
        w_pending_nxt = r_pending;
        w_dead_nxt    = r_dead_cnt;
        w_alive_nxt   = r_alive;

        case (r_state)
            ST_READY: begin
                w_y_nxt       = Y_INIT_V;
                w_vel_nxt     = '0;
                w_alive_nxt   = '0;
                w_pending_nxt = 1'b0;
                w_dead_nxt    = '0;
                // The start flap wins over a coincident frame tick: no motion
                // is applied on the transition cycle.
                if (r_flap_evt) begin
                    w_state_nxt = ST_PLAY;
                    w_vel_nxt   = FLAP_V;
                end
            end

            ST_PLAY: begin
                if (r_frame_tick) begin
                    w_alive_nxt   = w_alive_inc;
                    w_pending_nxt = 1'b0;
                    if (w_y_sum[11]) begin
                        // Hit the top of the screen: pin to row 0 and stop,
                        // unless a flap reload is due this frame.
                        w_y_nxt   = '0;
                        w_vel_nxt = w_flap_now ? FLAP_V : 5'sd0;
                    end else if (w_y_sum >= Y_MAX_S) begin
                        w_y_nxt     = Y_MAX_V;
                        w_vel_nxt   = '0;
                        w_state_nxt = ST_DEAD;
                    end else begin
                        w_y_nxt   = w_y_sum[10:0];
                        w_vel_nxt = w_flap_now ? FLAP_V : w_vel_cap;
                    end
                end else if (r_flap_evt) begin
                    // Several presses within one frame collapse into one.
                    w_pending_nxt = 1'b1;
                end
            end

            ST_DEAD: begin
                if (r_flap_evt && (r_dead_cnt == DEAD_MAX)) begin
                    w_state_nxt   = ST_READY;
                    w_y_nxt       = Y_INIT_V;
                    w_vel_nxt     = '0;
                    w_alive_nxt   = '0;
                    w_pending_nxt = 1'b0;
                    w_dead_nxt    = '0;
                end else if (r_frame_tick && (r_dead_cnt != DEAD_MAX)) begin
                    w_dead_nxt = r_dead_cnt + DC_W'(1);
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean READY.
                w_state_nxt   = ST_READY;
                w_y_nxt       = Y_INIT_V;
                w_vel_nxt     = '0;
                w_alive_nxt   = '0;
                w_pending_nxt = 1'b0;
                w_dead_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            r_state    <= ST_READY;
            r_y        <= Y_INIT_V;
            r_vel      <= '0;
            r_pending  <= 1'b0;
            r_dead_cnt <= '0;
            r_alive    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_y        <= w_y_nxt;
            r_vel      <= w_vel_nxt;
            r_pending  <= w_pending_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_alive    <= w_alive_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. r_y is always clamped to [0, Y_MAX], so its low 10 bits are
    // the full row value.
    // -------------------------------------------------------------------------
    assign bird_y       = r_y[9:0];
    assign state        = r_state;
    assign game_over    = (r_state == ST_DEAD);
    assign alive_frames = r_alive;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
`timescale 1ns/1ps
module tb_bird_motion_ctrl;

    localparam int M_Y_INIT = 215;
    localparam int M_Y_MAX  = 430;
    localparam int M_FLAP   = -8;
    localparam int M_VMAX   = 10;
    localparam int M_DEAD   = 60;
    localparam int W        = 29;

    // ---------------- clock / reset / DUT ----------------
    logic        dclk = 1'b0;
    logic        clr = 1'b1;
    logic        vsync = 1'b1;
    logic        flap = 1'b0;
    logic [9:0]  bird_y;
    logic [1:0]  state;
    logic        game_over;
    logic [15:0] alive_frames;

    always #20 dclk = ~dclk;

    bird_motion_ctrl dut (
        .dclk         (dclk),
        .clr          (clr),
        .vsync        (vsync),
        .flap         (flap),
        .bird_y       (bird_y),
        .state        (state),
        .game_over    (game_over),
        .alive_frames (alive_frames)
    );

    // ---------------- reference model ----------------
    int m_state, m_y, m_vel, m_alive, m_dead;
    bit m_pend;

    task automatic m_reset();
        m_state = 0; m_y = M_Y_INIT; m_vel = 0; m_alive = 0; m_dead = 0; m_pend = 0;
    endtask

    task automatic m_evt();
        if (m_state == 0) begin
            m_state = 1; m_vel = M_FLAP; m_pend = 0;
        end else if (m_state == 1) begin
            m_pend = 1;
        end else if (m_dead == M_DEAD) begin
            m_reset();
        end
    endtask

    task automatic m_tick();
        int ny, nv;
        bit fl;
        if (m_state == 1) begin
            ny = m_y + m_vel;
            fl = m_pend;
            nv = fl ? M_FLAP : ((m_vel + 1 > M_VMAX) ? M_VMAX : m_vel + 1);
            if (m_alive < 65535) m_alive++;
            m_pend = 0;
            if (ny < 0) begin
                m_y = 0; m_vel = fl ? M_FLAP : 0;
            end else if (ny >= M_Y_MAX) begin
                m_y = M_Y_MAX; m_state = 2;
            end else begin
                m_y = ny; m_vel = nv;
            end
        end else if (m_state == 2) begin
            if (m_dead < M_DEAD) m_dead++;
        end
    endtask

    function automatic logic [W-1:0] model_word();
        return {2'(m_state), (m_state == 2), 10'(m_y), 16'(m_alive)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check_out(input string name);
        logic [W-1:0] e, a;
        a = {state, game_over, bird_y, alive_frames};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected value queued, got state=%0d y=%0d", name, state, bird_y);
        end else begin
            e = exp_q.pop_front();
            if (a !== e)
                $display("FAIL %s: got state=%0d go=%0b y=%0d alive=%0d, expected state=%0d go=%0b y=%0d alive=%0d",
                         name, a[28:27], a[26], a[25:16], a[15:0], e[28:27], e[26], e[25:16], e[15:0]);
            else
                n_pass++;
        end
    endtask

    // ---------------- driver tasks (drive on negedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge dclk);
    endtask

    task automatic press();
        flap = 1'b1; idle(6);
        flap = 1'b0; idle(6);
    endtask

    task automatic tick_frame();
        vsync = 1'b0; idle(4);
        vsync = 1'b1; idle(4);
    endtask

    // Flap edge reaches the core 3 cycles after the pin, the tick 1 cycle
    // after vsync is registered low: start vsync 2 cycles after the pin.
    task automatic flap_with_tick();
        flap = 1'b1; idle(2);
        vsync = 1'b0; idle(4);
        vsync = 1'b1; flap = 1'b0; idle(6);
    endtask

    // ---------------- table of no-flap frames after the start flap ----------------
    typedef struct {
        int          flaps;
        logic [9:0]  exp_y;
        logic [1:0]  exp_state;
        logic [15:0] exp_alive;
    } vec_t;

    vec_t tbl [19];
    int   tbl_y [19] = '{207, 200, 194, 189, 185, 182, 180, 179, 179, 180,
                         182, 185, 189, 194, 200, 207, 215, 224, 234};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        for (int i = 0; i < 19; i++) begin
            tbl[i].flaps     = 0;
            tbl[i].exp_y     = 10'(tbl_y[i]);
            tbl[i].exp_state = 2'd1;
            tbl[i].exp_alive = 16'(i + 1);
        end

        // reset
        m_reset();
        idle(3);
        exp_q.push_back(model_word());
        check_out("reset");
        clr = 1'b0;
        idle(6);

        // start flap, then free fall through the table
        m_evt();
        exp_q.push_back(model_word());
        press();
        check_out("start_flap");

        for (int i = 0; i < 19; i++) begin
            repeat (tbl[i].flaps) begin press(); m_evt(); end
            m_tick();
            exp_q.push_back({tbl[i].exp_state, 1'b0, tbl[i].exp_y, tbl[i].exp_alive});
            tick_frame();
            check_out("fall_tbl");
        end

        guard = 0;
        while (m_state == 1 && guard < 60) begin
            m_tick();
            exp_q.push_back(model_word());
            tick_frame();
            check_out("fall_to_floor");
            guard++;
        end
        exp_q.push_back({2'd2, 1'b1, 10'd430, 16'd39});
        check_out("dead_at_floor");

        // DEAD: hold, early flap ignored, restart after DEAD_FRAMES
        for (int i = 0; i < 10; i++) begin
            m_tick();
            exp_q.push_back(model_word());
            tick_frame();
            check_out("dead_hold");
        end
        m_evt();
        exp_q.push_back(model_word());
        press();
        check_out("dead_early_flap");
        for (int i = 0; i < 50; i++) begin
            m_tick();
            exp_q.push_back(model_word());
            tick_frame();
            check_out("dead_count");
        end
        m_evt();
        exp_q.push_back({2'd0, 1'b0, 10'd215, 16'd0});
        press();
        check_out("restart");

        // climb with one flap per frame until the top clamp
        m_evt();
        exp_q.push_back(model_word());
        press();
        check_out("start_flap2");
        guard = 0;
        while (guard < 40) begin
            press(); m_evt();
            m_tick();
            exp_q.push_back(model_word());
            tick_frame();
            check_out("climb");
            guard++;
            if (m_y == 0) break;
        end
        exp_q.push_back({2'd1, 1'b0, 10'd0, 16'(guard)});
        check_out("top_clamp");

        // coast down a little, then flap on the tick cycle itself
        for (int i = 0; i < 6; i++) begin
            m_tick();
            exp_q.push_back(model_word());
            tick_frame();
            check_out("coast");
        end
        m_evt(); m_tick();
        exp_q.push_back(model_word());
        flap_with_tick();
        check_out("flap_on_tick");
        for (int i = 0; i < 2; i++) begin
            m_tick();
            exp_q.push_back(model_word());
            tick_frame();
            check_out("after_flap_on_tick");
        end

        // clr on a tick cycle mid-PLAY with the button held
        flap = 1'b1; idle(6); m_evt();
        vsync = 1'b0; idle(1);
        clr = 1'b1; idle(1);
        m_reset();
        exp_q.push_back(model_word());
        check_out("clr_on_tick");
        clr = 1'b0;
        idle(3); vsync = 1'b1; idle(4);
        tick_frame(); tick_frame();
        exp_q.push_back(model_word());
        check_out("held_button_no_flap");
        flap = 1'b0; idle(6);

        // start flap coinciding with a tick: transition only, no motion
        m_evt();
        exp_q.push_back(model_word());
        flap_with_tick();
        check_out("start_on_tick");
        m_tick();
        exp_q.push_back({2'd1, 1'b0, 10'd207, 16'd1});
        tick_frame();
        check_out("first_tick_after_start");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
